// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel output buffer with almost-full pause flag.
// Optional build macro VC_FIFO_ERR_CLEAR_EN adds the err_clr input, which
// clears the sticky error flag. Without the macro, error clears only on reset.
module vc_fifo #(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   input  logic [ADDR_WIDTH:0]   th_afull,
   input  logic [ADDR_WIDTH:0]   th_aempty,
`ifdef VC_FIFO_ERR_CLEAR_EN
   input  logic                  err_clr,
`endif
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  pause,
   output logic                  almost_empty,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  pop_ok;
   logic                  push_ok;
   logic                  err_evt;

   // Accept/reject decisions; a push into a full buffer is allowed only when a pop frees a slot
   always_comb begin
      pop_ok  = 1'b0;
      push_ok = 1'b0;
      err_evt = 1'b0;
      pop_ok  = pop && (count != CW'(0));
      push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
      err_evt = (push && !push_ok) || (pop && !pop_ok);
   end

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
         end
      end
   end

   // Registered read port: data_out holds its value when no pop is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (pop_ok) begin
            data_out <= mem[rd_ptr];
         end
      end
   end

   // Sticky overflow/underflow flag; a new event wins over a clear request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error <= 1'b0;
      end else if (err_evt) begin
         error <= 1'b1;
`ifdef VC_FIFO_ERR_CLEAR_EN
      end else if (err_clr) begin
         error <= 1'b0;
`endif
      end
   end

   // Status flags decoded from the occupancy register
   always_comb begin
      full         = (count == CW'(DEPTH));
      empty        = (count == CW'(0));
      pause        = (count >= th_afull);
      almost_empty = (count <= th_aempty);
   end

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed plus randomized checking of vc_fifo against a queue model.
module tb_vc_fifo;

   localparam int unsigned DW    = 6;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = AW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [CW-1:0] th_afull;
   logic [CW-1:0] th_aempty;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          full;
   logic          empty;
   logic          pause;
   logic          almost_empty;
   logic          error;
   logic [CW-1:0] count;
`ifdef VC_FIFO_ERR_CLEAR_EN
   logic          err_clr;
`endif

   vc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .th_afull     (th_afull),
      .th_aempty    (th_aempty),
`ifdef VC_FIFO_ERR_CLEAR_EN
      .err_clr      (err_clr),
`endif
      .data_out     (data_out),
      .valid_out    (valid_out),
      .full         (full),
      .empty        (empty),
      .pause        (pause),
      .almost_empty (almost_empty),
      .error        (error),
      .count        (count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered queue of stored words plus the visible read register
   logic [DW-1:0] q[$];
   logic          m_err;
   logic          m_valid;
   logic [DW-1:0] m_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == int'(DEPTH)));
      chk({tag, ".pause"}, 32'(pause), 32'(n >= int'(th_afull)));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= int'(th_aempty)));
      chk({tag, ".error"}, 32'(error), 32'(m_err));
      chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
      chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
   endtask

   task automatic model_reset();
      q.delete();
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge
   task automatic step(input logic p, input logic [DW-1:0] d, input logic r, input logic c, input string tag);
      bit pa, wa, ev;
      push    = p;
      data_in = d;
      pop     = r;
`ifdef VC_FIFO_ERR_CLEAR_EN
      err_clr = c;
`endif
      @(posedge clk);
      pa = r && (q.size() > 0);
      wa = p && ((q.size() < int'(DEPTH)) || pa);
      ev = (p && !wa) || (r && !pa);
      if (pa) begin
         m_dout  = q.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (wa) q.push_back(d);
`ifdef VC_FIFO_ERR_CLEAR_EN
      if (ev) m_err = 1'b1;
      else if (c) m_err = 1'b0;
`else
      if (ev) m_err = 1'b1;
      if (c) begin end
`endif
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
`ifdef VC_FIFO_ERR_CLEAR_EN
      err_clr = 1'b0;
`endif
      check_all(tag);
   endtask

   task automatic do_reset(input logic [CW-1:0] ta, input logic [CW-1:0] tae);
      reset     = 1'b1;
      th_afull  = ta;
      th_aempty = tae;
      model_reset();
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
`ifdef VC_FIFO_ERR_CLEAR_EN
      err_clr = 1'b0;
`endif
      th_afull  = 3'd3;
      th_aempty = 3'd1;

      // Basic ordering and pause threshold
      do_reset(3'd3, 3'd1);
      step(1, 6'h15, 0, 0, "t1.push");
      step(1, 6'h2A, 0, 0, "t1.push");
      step(1, 6'h3F, 0, 0, "t1.push");
      chk("t1.pause_at3", 32'(pause), 32'd1);
      step(0, 0, 1, 0, "t1.pop");
      chk("t1.d0", 32'(data_out), 32'h15);
      step(0, 0, 1, 0, "t1.pop");
      chk("t1.d1", 32'(data_out), 32'h2A);
      step(0, 0, 1, 0, "t1.pop");
      chk("t1.d2", 32'(data_out), 32'h3F);
      chk("t1.empty", 32'(empty), 32'd1);

      // Overflow drops the word
      for (int i = 0; i < 4; i++) step(1, DW'(6'h21 + i), 0, 0, "t2.fill");
      step(1, 6'h01, 0, 0, "t2.ovf");
      chk("t2.err", 32'(error), 32'd1);
      chk("t2.cnt", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, "t2.drain");
         chk("t2.data", 32'(data_out), 32'(6'h21 + i));
      end

      // Full with simultaneous push and pop
      do_reset(3'd3, 3'd1);
      for (int i = 0; i < 4; i++) step(1, DW'(6'h30 + i), 0, 0, "t3.fill");
      step(1, 6'h07, 1, 0, "t3.both");
      chk("t3.cnt", 32'(count), 32'd4);
      chk("t3.err", 32'(error), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "t3.drain");
      chk("t3.last", 32'(data_out), 32'h07);

      // Underflow and push+pop on empty
      do_reset(3'd3, 3'd1);
      step(1, 6'h2C, 0, 0, "t4.push");
      step(0, 0, 1, 0, "t4.pop");
      step(0, 0, 1, 0, "t4.unf");
      chk("t4.err", 32'(error), 32'd1);
      chk("t4.hold", 32'(data_out), 32'h2C);
      chk("t4.valid", 32'(valid_out), 32'd0);
      step(1, 6'h11, 1, 0, "t4.both");
      chk("t4.cnt1", 32'(count), 32'd1);

      // Pointer wrap
      do_reset(3'd3, 3'd1);
      for (int i = 0; i < 10; i++) begin
         step(1, DW'(i), 0, 0, "t5.push");
         step(0, 0, 1, 0, "t5.pop");
         chk("t5.order", 32'(data_out), 32'(i));
      end
      chk("t5.err", 32'(error), 32'd0);

      // Asynchronous reset mid-burst, with error set beforehand
      do_reset(3'd2, 3'd0);
      step(0, 0, 1, 0, "t6.unf");
      for (int i = 0; i < 3; i++) step(1, DW'(6'h0A + i), 0, 0, "t6.fill");
      #2 reset = 1'b1;
      model_reset();
      #1 check_all("t6.async");
      chk("t6.cnt0", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check_all("t6.post");

`ifdef VC_FIFO_ERR_CLEAR_EN
      step(0, 0, 1, 0, "t7.unf");
      chk("t7.set", 32'(error), 32'd1);
      step(0, 0, 0, 1, "t7.clr");
      chk("t7.clr", 32'(error), 32'd0);
      step(0, 0, 1, 1, "t7.clr_vs_evt");
      chk("t7.keep", 32'(error), 32'd1);
`endif

      // Randomized traffic with random thresholds, including 0 and above DEPTH
      for (int e = 0; e < 8; e++) begin
         do_reset(CW'($urandom_range(0, 7)), CW'($urandom_range(0, 7)));
         for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 5), "rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Per-virtual-channel buffer that sits directly downstream of the main-FIFO pop/flow controller. It accepts words popped from the main FIFO and queues them for the output arbiter. It produces the almost-full "pause" flag that the flow controller consumes as fifo_pause_vc0 or fifo_pause_vc1. One instance is built per VC; each instance is fully independent.

Parameters:
DATA_WIDTH, 6, width of each stored word.
ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 4).

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
push  input  1  write request; data_in is sampled on the same edge.
data_in  input  DATA_WIDTH  word to store.
pop  input  1  read request from the downstream arbiter.
th_afull  input  ADDR_WIDTH+1  almost-full threshold, static after reset.
th_aempty  input  ADDR_WIDTH+1  almost-empty threshold, static after reset.
data_out  output  DATA_WIDTH  registered read data.
valid_out  output  1  high for one cycle when data_out holds a word popped on the previous edge.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
pause  output  1  almost-full; count >= th_afull; feeds the flow controller's pause input.
almost_empty  output  1  count <= th_aempty.
error  output  1  sticky overflow/underflow flag.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Count register is ADDR_WIDTH+1 bits wide and saturates at neither end, because illegal operations are blocked.
- Reset (async, any time, including mid-burst): the following are cleared to 0:
  - wr_ptr, rd_ptr, count
  - data_out, valid_out, error
  - Result: empty=1, full=0. pause and almost_empty follow the thresholds against count=0. Array contents are don't-care.
- Push accepted iff push=1 and (count<DEPTH or pop accepted on the same edge).
  - Accepted push: mem[wr_ptr]<=data_in, wr_ptr+1.
- Pop accepted iff pop=1 and count>0.
  - Accepted pop: data_out<=mem[rd_ptr], rd_ptr+1, valid_out<=1 on that edge.
  - Otherwise valid_out<=0 and data_out holds its value.
- Read latency: one cycle. Data is visible after the edge that accepted the pop.
- Count update:
  - +1 for push-only.
  - -1 for pop-only.
  - Unchanged for accepted push+pop or for neither.
- Full with simultaneous push+pop: both are accepted, count stays DEPTH, no error.
- Empty with simultaneous push+pop: the push is accepted and the pop is rejected (no bypass). error<=1, count becomes 1, valid_out=0.
- Overflow: push while full without an accepted pop. The word is dropped, the pointers are unchanged, error<=1.
- Underflow: pop while empty. Ignored, error<=1.
- error is sticky until reset (see Optional Feature).
- Flags full, empty, pause, almost_empty are combinational from the count register, so they take effect in the cycle after the causing edge.
- Thresholds: th_afull is compared >=, th_aempty is compared <=.
  - th_afull=0 forces pause=1.
  - th_afull > DEPTH forces pause=0.

Optional Feature:
Macro VC_FIFO_ERR_CLEAR_EN.
- Defined: adds input port err_clr (1 bit). err_clr=1 clears error on the next edge, unless a new overflow/underflow occurs on that same edge, in which case error stays 1.
- Undefined: the port is absent and error clears only on reset.

Test Plan:
1. Reset, then push 0x15, 0x2A, 0x3F with th_afull=3 -> count=3 and pause=1 in the cycle after the 3rd push. Then 3 pops -> data_out 0x15, 0x2A, 0x3F, each with valid_out=1 one cycle after its pop, final empty=1.
2. Fill to DEPTH=4, push 0x01 -> word dropped, error=1, count=4. Subsequent pops return the original 4 words only.
3. Full with push+pop on the same edge (data_in=0x07) -> count stays 4, error=0, and 0x07 emerges as the 4th subsequent pop after that edge.
4. Empty, pop only -> error=1, valid_out=0, data_out unchanged. Empty with push+pop -> count=1, error=1.
5. Wrap: 10 push/pop pairs with data 0..9 -> output order 0..9 exactly, pointers wrap with no loss, error=0.
6. Assert reset mid-burst at count=3 -> immediately count=0, empty=1, valid_out=0, error=0. With VC_FIFO_ERR_CLEAR_EN defined, trigger error then pulse err_clr -> error=0 on the next edge.
